// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS ID-stage register file slice.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
  typedef logic [ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/id_regfile_gpr_file.sv
// 2-read / 1-write GPR array with r0 hardwired to zero and write-first bypass.
module gpr_file #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);
  import mips_pkg::*;

  logic [DATA_W-1:0] r_regs [2**ADDR_W];
  logic              w_wr_ok;

  assign w_wr_ok = i_we && (i_waddr != ADDR_W'(REG_ZERO));

  // Reset clears every entry and suppresses any WB write in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata_a = '0;
    o_rdata_b = '0;
    if (i_raddr_a != ADDR_W'(REG_ZERO))
      o_rdata_a = (w_wr_ok && i_waddr == i_raddr_a) ? i_wdata : r_regs[i_raddr_a];
    if (i_raddr_b != ADDR_W'(REG_ZERO))
      o_rdata_b = (w_wr_ok && i_waddr == i_raddr_b) ? i_wdata : r_regs[i_raddr_b];
  end
endmodule

// File: rtl/id_regfile_stage.sv
// ID-stage operand read, load-use hazard detection and ID/EX pipeline register.
// Optional ID_STALL_COUNT_EN adds a saturating stall_count output.
module id_regfile_stage #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic              id_mem_read,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [ADDR_W-1:0] ex_rs_addr,
  output logic [ADDR_W-1:0] ex_rt_addr,
  output logic [ADDR_W-1:0] ex_dest,
  output logic              ex_mem_read
`ifdef ID_STALL_COUNT_EN
  ,output logic [31:0]      stall_count
`endif
);
  import mips_pkg::*;

  logic [DATA_W-1:0] w_rs_val, w_rt_val;
  logic              w_lu, w_wb_live;
  logic              r_ex_valid, r_ex_mem_read;
  logic [DATA_W-1:0] r_ex_rs_data, r_ex_rt_data;
  logic [ADDR_W-1:0] r_ex_rs_addr, r_ex_rt_addr, r_ex_dest;

  gpr_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_gpr (
    .clk       (clk),
    .rst       (rst),
    .i_we      (wb_we),
    .i_waddr   (wb_addr),
    .i_wdata   (wb_data),
    .i_raddr_a (id_rs),
    .i_raddr_b (id_rt),
    .o_rdata_a (w_rs_val),
    .o_rdata_b (w_rt_val)
  );

  assign w_wb_live = wb_we && (wb_addr != ADDR_W'(REG_ZERO));

  // Handshake: stall=1 means ID must hold its instruction (PC and IF/ID frozen);
  // ID/EX accepts the ID slot only on a cycle with no flush, no ex_hold and no load-use.
  assign w_lu = id_valid && r_ex_valid && r_ex_mem_read && (r_ex_dest != ADDR_W'(REG_ZERO)) &&
                ((r_ex_dest == id_rs) || (id_uses_rt && (r_ex_dest == id_rt)));
  assign stall = !rst && (w_lu || ex_hold);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid    <= 1'b0;
      r_ex_mem_read <= 1'b0;
      r_ex_rs_data  <= '0;
      r_ex_rt_data  <= '0;
      r_ex_rs_addr  <= '0;
      r_ex_rt_addr  <= '0;
      r_ex_dest     <= '0;
    end else if (flush || (w_lu && !ex_hold)) begin
      r_ex_valid    <= 1'b0;
      r_ex_mem_read <= 1'b0;
      r_ex_dest     <= '0;
    end else if (ex_hold) begin
      // Held operands track WB so EX never consumes a stale value.
      if (w_wb_live && wb_addr == r_ex_rs_addr) r_ex_rs_data <= wb_data;
      if (w_wb_live && wb_addr == r_ex_rt_addr) r_ex_rt_data <= wb_data;
    end else begin
      r_ex_valid    <= id_valid;
      r_ex_rs_data  <= w_rs_val;
      r_ex_rt_data  <= w_rt_val;
      r_ex_rs_addr  <= id_rs;
      r_ex_rt_addr  <= id_rt;
      r_ex_dest     <= id_valid ? id_dest : '0;
      r_ex_mem_read <= id_valid && id_mem_read;
    end
  end

  assign ex_valid    = r_ex_valid;
  assign ex_rs_data  = r_ex_rs_data;
  assign ex_rt_data  = r_ex_rt_data;
  assign ex_rs_addr  = r_ex_rs_addr;
  assign ex_rt_addr  = r_ex_rt_addr;
  assign ex_dest     = r_ex_dest;
  assign ex_mem_read = r_ex_mem_read;

`ifdef ID_STALL_COUNT_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (rst) r_stall_count <= '0;
    else if (w_lu && !flush && !ex_hold && r_stall_count != 32'hFFFF_FFFF)
      r_stall_count <= r_stall_count + 32'd1;
  end

  assign stall_count = r_stall_count;
`endif
endmodule

// File: tb/tb_id_regfile_stage.sv
// Directed self-checking bench for id_regfile_stage (stall_count checks under ID_STALL_COUNT_EN).
module tb_id_regfile_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_uses_rt, id_mem_read;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush, ex_hold;
  logic        stall, ex_valid, ex_mem_read;
  logic [31:0] ex_rs_data, ex_rt_data;
  logic [4:0]  ex_rs_addr, ex_rt_addr, ex_dest;
`ifdef ID_STALL_COUNT_EN
  logic [31:0] stall_count;
`endif

  int n_total = 0;
  int n_bad   = 0;

  id_regfile_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_dest(id_dest), .id_mem_read(id_mem_read),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .ex_hold(ex_hold),
    .stall(stall), .ex_valid(ex_valid),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr),
    .ex_dest(ex_dest), .ex_mem_read(ex_mem_read)
`ifdef ID_STALL_COUNT_EN
    ,.stall_count(stall_count)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urt, input logic [4:0] dst, input logic mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_dest = dst; id_mem_read = mr;
  endtask

  task automatic drive_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    wb_we = we; wb_addr = a; wb_data = d;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_hold = 1'b1;
    drive_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1);
    drive_wb(1'b0, 5'd0, 32'h0);
    step(); step();
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_ex_dest", 32'(ex_dest), 32'd0);
    check("rst_ex_mem_read", 32'(ex_mem_read), 32'd0);
    check("rst_ex_rs_data", ex_rs_data, 32'd0);
`ifdef ID_STALL_COUNT_EN
    check("rst_stall_count", stall_count, 32'd0);
`endif
    rst = 1'b0; ex_hold = 1'b0;

    // read after reset: all GPRs zero
    drive_id(1'b1, 5'd5, 5'd6, 1'b1, 5'd10, 1'b0);
    step();
    check("rd56_rs", ex_rs_data, 32'd0);
    check("rd56_rt", ex_rt_data, 32'd0);
    check("rd56_valid", 32'(ex_valid), 32'd1);
    check("rd56_dest", 32'(ex_dest), 32'd10);
    check("rd56_rs_addr", 32'(ex_rs_addr), 32'd5);
    check("rd56_rt_addr", 32'(ex_rt_addr), 32'd6);

    // r0 write is dropped and never bypassed
    drive_wb(1'b1, 5'd0, 32'hDEAD);
    drive_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
    step();
    check("r0_bypass", ex_rs_data, 32'd0);
    drive_wb(1'b0, 5'd0, 32'h0);
    step();
    check("r0_read", ex_rs_data, 32'd0);

    // same-cycle WB bypass
    drive_wb(1'b1, 5'd7, 32'h1234);
    drive_id(1'b1, 5'd7, 5'd7, 1'b1, 5'd10, 1'b0);
    settle();
    check("byp_stall", 32'(stall), 32'd0);
    step();
    check("byp_rs", ex_rs_data, 32'h1234);
    check("byp_rt", ex_rt_data, 32'h1234);
    drive_wb(1'b1, 5'd8, 32'h55);
    drive_id(1'b1, 5'd7, 5'd0, 1'b0, 5'd10, 1'b0);
    step();
    check("r7_array", ex_rs_data, 32'h1234);
    drive_wb(1'b0, 5'd0, 32'h0);

    // load-use: lw r9 followed by add using r9, repeated three times
    for (int k = 0; k < 3; k++) begin
      drive_id(1'b1, 5'd7, 5'd0, 1'b0, 5'd9, 1'b1);
      step();
      check("lw_mem_read", 32'(ex_mem_read), 32'd1);
      check("lw_dest", 32'(ex_dest), 32'd9);
      drive_id(1'b1, 5'd9, 5'd8, 1'b1, 5'd11, 1'b0);
      settle();
      check("lu_stall", 32'(stall), 32'd1);
      step();
      check("lu_bubble_valid", 32'(ex_valid), 32'd0);
      check("lu_bubble_dest", 32'(ex_dest), 32'd0);
      check("lu_bubble_mr", 32'(ex_mem_read), 32'd0);
      check("lu_resolved", 32'(stall), 32'd0);
      step();
      check("lu_add_valid", 32'(ex_valid), 32'd1);
      check("lu_add_dest", 32'(ex_dest), 32'd11);
      check("lu_add_rs_addr", 32'(ex_rs_addr), 32'd9);
      check("lu_add_rt", ex_rt_data, 32'h55);
    end

    // rt=9 but not a true source: no hazard
    drive_id(1'b1, 5'd7, 5'd0, 1'b0, 5'd9, 1'b1);
    step();
    drive_id(1'b1, 5'd1, 5'd9, 1'b0, 5'd12, 1'b0);
    settle();
    check("nort_stall", 32'(stall), 32'd0);
    step();
    check("nort_valid", 32'(ex_valid), 32'd1);
    check("nort_dest", 32'(ex_dest), 32'd12);

    // load to r0 never creates a hazard
    drive_id(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b1);
    step();
    drive_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd12, 1'b0);
    settle();
    check("r0_lu_stall", 32'(stall), 32'd0);

    // ex_hold for 3 cycles with WB refreshing the held rt operand
    drive_id(1'b1, 5'd1, 5'd3, 1'b1, 5'd13, 1'b0);
    step();
    check("hold_pre_rt", ex_rt_data, 32'd0);
    ex_hold = 1'b1;
    drive_id(1'b1, 5'd2, 5'd4, 1'b1, 5'd20, 1'b1);
    for (int k = 0; k < 3; k++) begin
      if (k == 0) drive_wb(1'b1, 5'd3, 32'hA5A5);
      else        drive_wb(1'b0, 5'd0, 32'h0);
      settle();
      check("hold_stall", 32'(stall), 32'd1);
      step();
    end
    check("hold_rt", ex_rt_data, 32'hA5A5);
    check("hold_rs", ex_rs_data, 32'd0);
    check("hold_rs_addr", 32'(ex_rs_addr), 32'd1);
    check("hold_dest", 32'(ex_dest), 32'd13);
    check("hold_mr", 32'(ex_mem_read), 32'd0);
    check("hold_valid", 32'(ex_valid), 32'd1);
    ex_hold = 1'b0;

    // flush coincident with a load-use hazard
    drive_id(1'b1, 5'd7, 5'd0, 1'b0, 5'd9, 1'b1);
    step();
    drive_id(1'b1, 5'd9, 5'd0, 1'b0, 5'd11, 1'b0);
    flush = 1'b1;
    settle();
    check("flush_stall", 32'(stall), 32'd1);
    step();
    flush = 1'b0;
    check("flush_valid", 32'(ex_valid), 32'd0);
    check("flush_dest", 32'(ex_dest), 32'd0);
    drive_id(1'b1, 5'd8, 5'd3, 1'b1, 5'd14, 1'b0);
    step();
    check("post_flush_valid", 32'(ex_valid), 32'd1);
    check("post_flush_dest", 32'(ex_dest), 32'd14);
    check("post_flush_rs", ex_rs_data, 32'h55);
    check("post_flush_rt", ex_rt_data, 32'hA5A5);

    // id_valid=0 loads zero dest and mem_read
    drive_id(1'b0, 5'd8, 5'd3, 1'b1, 5'd15, 1'b1);
    step();
    check("inv_valid", 32'(ex_valid), 32'd0);
    check("inv_dest", 32'(ex_dest), 32'd0);
    check("inv_mr", 32'(ex_mem_read), 32'd0);
`ifdef ID_STALL_COUNT_EN
    check("stall_count", stall_count, 32'd3);
`endif

    // reset mid-operation clears GPRs and blocks the concurrent WB write
    rst = 1'b1;
    drive_wb(1'b1, 5'd8, 32'h77);
    step();
    rst = 1'b0;
    drive_wb(1'b0, 5'd0, 32'h0);
    check("mid_rst_valid", 32'(ex_valid), 32'd0);
`ifdef ID_STALL_COUNT_EN
    check("mid_rst_stall_count", stall_count, 32'd0);
`endif
    drive_id(1'b1, 5'd8, 5'd3, 1'b1, 5'd14, 1'b0);
    step();
    check("mid_rst_r8", ex_rs_data, 32'd0);
    check("mid_rst_r3", ex_rt_data, 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
